serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have rst_n, input, 1, with asynchronous active-low reset.
REQ-004 The block SHALL have start, input, 1, a request to capture operands and begin a subtraction.
REQ-005 The block SHALL have a, input, WIDTH, the minuend.
REQ-006 The block SHALL have b, input, WIDTH, the subtrahend.
REQ-007 The block SHALL have busy, output, 1, high while bits are being processed.
REQ-008 The block SHALL have done, output, 1, a one-cycle pulse indicating that the result is valid.
REQ-009 The block SHALL have diff, output, WIDTH, the result a - b modulo 2^WIDTH.
REQ-010 The block SHALL have bout, output, 1, the final borrow, which is 1 when a < b unsigned.

Function
REQ-011 The block SHALL implement a three-state FSM with states IDLE, SHIFT and DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture a and b into shift registers, clear the borrow flop and the bit counter, and move to SHIFT.
REQ-013 In SHIFT, each cycle SHALL process one bit, LSB first:
- d = a_i ^ b_i ^ bin;
- bnext = (~a_i & b_i) | (~(a_i ^ b_i) & bin);
- d is shifted into the MSB of the result register;
- the operand registers shift right by one;
- the borrow flop takes bnext.
REQ-014 The bit counter SHALL run 0..WIDTH-1; on the edge that processes bit WIDTH-1 the FSM SHALL move to DONE.
REQ-015 In DONE, diff SHALL equal the full result register and bout SHALL equal the borrow flop; done SHALL be 1 for exactly this cycle.
REQ-016 From DONE, the FSM SHALL move to IDLE if start=0, or back to SHIFT with new operands if start=1 (back-to-back operation).
REQ-017 Timing: with start sampled at edge E0, busy SHALL be 1 for cycles E0..E0+WIDTH-1 and done SHALL be 1 for the cycle after edge E0+WIDTH; latency is therefore WIDTH+1 cycles, start to done.
REQ-018 start=1 while in SHIFT SHALL be ignored, and the operands on a and b SHALL be sampled only at the accept edge.
REQ-019 diff and bout SHALL hold their last result through IDLE until the next DONE.
REQ-020 While in SHIFT, diff SHALL show the partially shifted register; only its value while done=1 is guaranteed.
REQ-021 busy and done SHALL never be 1 in the same cycle.
REQ-022 Operand or result values of all zeros or all ones SHALL need no special handling; wrap-around is modulo 2^WIDTH.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE, with busy=0, done=0, diff=0, bout=0, the counter at 0 and the operand registers at 0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release the block SHALL accept start on the first rising edge.
REQ-025 Reset SHALL be released synchronously by the system; the block SHALL not require internal synchronisers.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the counter-width function clog2.
REQ-027 One combinational sub-module, fullsubtractor (ports x, y, bin, bout, diff), SHALL implement the per-bit equations of REQ-013 and be instantiated once in the datapath.
REQ-028 All other logic (FSM, counter, shift registers) SHALL reside in serial_subtractor; the total RTL SHALL be under 400 lines.

Verification (WIDTH=8)
REQ-029 Basic subtraction: a=0x5A, b=0x23, start for 1 cycle -> done 9 cycles later with diff=0x37, bout=0; busy high for exactly 8 cycles.
REQ-030 Underflow: a=0x00, b=0x01 -> diff=0xFF, bout=1; and a=0x80, b=0x80 -> diff=0x00, bout=0.
REQ-031 Start while busy: start pulsed again at cycle 3 of SHIFT with a=0xFF, b=0x00 -> ignored, first result unaffected, only one done pulse.
REQ-032 Back-to-back: start held high through DONE with a=0x10, b=0x20 -> next done 9 cycles after the first, with diff=0xF0, bout=1.
REQ-033 Reset mid-operation: rst_n low at cycle 4 of SHIFT -> all outputs 0 at once, no done pulse; a following start with a=0x03, b=0x01 -> diff=0x02.
REQ-034 Random check: 1000 random a/b pairs -> {bout,diff} equals the unsigned (a - b) 9-bit reference model every time.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: FSM state encoding and counter-width helper
package serial_subtractor_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// fullsubtractor: one-bit x - y - bin with borrow out
module fullsubtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic bout,
    output logic diff
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one bit per cycle
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] ra, rb, res;
    logic             brw, d, bn, accept, last;

    fullsubtractor u_fs (
        .x    (ra[0]),
        .y    (rb[0]),
        .bin  (brw),
        .bout (bn),
        .diff (d)
    );

    // start is only honoured outside SHIFT, so a running subtraction cannot be disturbed
    assign accept = start && state != SHIFT;
    assign last   = state == SHIFT && cnt == LAST;

    always_comb begin
        nxt = accept ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            brw   <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                ra  <= a;
                rb  <= b;
                brw <= 1'b0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                ra  <= ra >> 1;
                rb  <= rb >> 1;
                res <= {d, res[WIDTH-1:1]};
                brw <= bn;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy = state == SHIFT;
    assign done = state == DONE;
    assign diff = res;
    assign bout = brw;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: vector table, corner sequences and random check vs a - b
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         busy, done, bout;
    logic [W-1:0] diff;

    int tests = 0;
    int fails = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bo;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic launch(input logic [W-1:0] ia, input logic [W-1:0] ib);
        a = ia;
        b = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // current negedge counts as cycle 1 after the start edge
    task automatic wait_done(output logic [W-1:0] d, output logic bo,
                             output int lat, output int bc, output int ov);
        d = '0;
        bo = 1'b0;
        lat = 0;
        bc = 0;
        ov = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (busy && done) ov++;
            if (busy) bc++;
            if (done) begin
                lat = k;
                d = diff;
                bo = bout;
                break;
            end
        end
    endtask

    initial begin
        logic [W-1:0] d, ra, rb;
        logic         bo;
        logic [W:0]   m;
        int           lat, bc, ov, nd;

        tv[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
        tv[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tv[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
        tv[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tv[4] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        tv[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        tv[6] = '{8'h10, 8'h20, 8'hF0, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_outputs", {22'd0, busy, done, diff, bout}, 32'd0);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            launch(tv[i].a, tv[i].b);
            wait_done(d, bo, lat, bc, ov);
            check($sformatf("vec%0d_diff", i), {24'd0, d}, {24'd0, tv[i].d});
            check($sformatf("vec%0d_bout", i), {31'd0, bo}, {31'd0, tv[i].bo});
            check($sformatf("vec%0d_latency", i), lat, 9);
            check($sformatf("vec%0d_busy_cycles", i), bc, 8);
            check($sformatf("vec%0d_overlap", i), ov, 0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check($sformatf("vec%0d_hold", i), {23'd0, bout, diff}, {23'd0, tv[i].bo, tv[i].d});
        end

        // start while busy must be ignored
        @(negedge clk);
        launch(8'h5A, 8'h23);
        repeat (2) @(negedge clk);
        a = 8'hFF;
        b = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        d = '0;
        repeat (20) begin
            if (done) begin
                nd++;
                d = diff;
            end
            @(negedge clk);
        end
        check("busy_start_dones", nd, 1);
        check("busy_start_diff", {24'd0, d}, 32'h37);

        // back-to-back: start held through DONE
        launch(8'h5A, 8'h23);
        wait_done(d, bo, lat, bc, ov);
        check("b2b_first_diff", {24'd0, d}, 32'h37);
        launch(8'h10, 8'h20);
        wait_done(d, bo, lat, bc, ov);
        check("b2b_gap", lat, 9);
        check("b2b_second", {23'd0, bo, d}, {23'd0, 1'b1, 8'hF0});

        // reset mid-SHIFT
        @(negedge clk);
        launch(8'h5A, 8'h23);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {22'd0, busy, done, diff, bout}, 32'd0);
        @(negedge clk);
        check("midreset_hold", {22'd0, busy, done, diff, bout}, 32'd0);
        rst_n = 1'b1;
        launch(8'h03, 8'h01);
        wait_done(d, bo, lat, bc, ov);
        check("postreset_latency", lat, 9);
        check("postreset_result", {23'd0, bo, d}, {23'd0, 1'b0, 8'h02});

        // random pairs against plain 9-bit arithmetic
        for (int i = 0; i < 1000; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            m = {1'b0, ra} - {1'b0, rb};
            @(negedge clk);
            launch(ra, rb);
            wait_done(d, bo, lat, bc, ov);
            check($sformatf("rand%0d_%0h_%0h", i, ra, rb), {23'd0, bo, d}, {23'd0, m});
            if (lat != 9 || bc != 8 || ov != 0)
                check($sformatf("rand%0d_timing", i), {lat[7:0], bc[7:0], ov[15:0]}, {8'd9, 8'd8, 16'd0});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
